bp_l15_encoder: RTL



---
 rtl/bp_l15_pkg.sv | 33 +++
 rtl/bp_l15_req_tracker.sv | 63 ++++++
 rtl/bp_l15_encoder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bp_l15_pkg.sv
// Shared types and constants for the BP <- L1.5 response path: return-type
// codes, the nc_size encoding, encoder FSM states and the tracker entry layout.
package bp_l15_pkg;

    localparam logic [3:0] LOAD_RET = 4'h0;
    localparam logic [3:0] ST_ACK   = 4'h4;
    localparam logic [3:0] INV_RET  = 4'h3;
    localparam logic [3:0] INT_RET  = 4'h7;

    localparam int DEFAULT_PADDR_WIDTH   = 40;
    localparam int DEFAULT_PAYLOAD_WIDTH = 22;

    typedef enum logic [1:0] {
        NC_SIZE_1B = 2'd0,
        NC_SIZE_2B = 2'd1,
        NC_SIZE_4B = 2'd2,
        NC_SIZE_8B = 2'd3
    } nc_size_e;

    typedef enum logic {
        READY = 1'b0,
        SEND  = 1'b1
    } enc_state_e;

    // Default-width entry; the encoder builds its own copy at its parameter widths.
    typedef struct packed {
        logic                             store;
        logic [DEFAULT_PADDR_WIDTH-1:0]   addr;
        nc_size_e                         size;
        logic [DEFAULT_PAYLOAD_WIDTH-1:0] payload;
    } tracker_entry_t;

endpackage

// File: rtl/bp_l15_req_tracker.sv
// In-order circular FIFO of requests accepted by L1.5, awaiting their return.
// A push while full is ignored unless a pop happens in the same cycle.
module bp_l15_req_tracker
    import bp_l15_pkg::*;
#(
    parameter int  els_p   = 4,
    parameter type entry_t = tracker_entry_t
) (
    input  logic   clk_i,
    input  logic   reset_n_i,
    input  logic   push_i,
    input  entry_t entry_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output entry_t head_o
);

    localparam int                PtrWidth = $clog2(els_p);
    localparam logic [PtrWidth:0] Depth    = (PtrWidth + 1)'(els_p);
    localparam logic [PtrWidth:0] CountOne = (PtrWidth + 1)'(1);
    localparam logic [PtrWidth-1:0] PtrOne = PtrWidth'(1);

    entry_t              entries_q [els_p];
    logic [PtrWidth-1:0] rdPtr_q;
    logic [PtrWidth-1:0] wrPtr_q;
    logic [PtrWidth:0]   count_q;
    logic                doPush;
    logic                doPop;

    assign full_o  = (count_q == Depth);
    assign empty_o = (count_q == '0);
    assign head_o  = entries_q[rdPtr_q];

    // A simultaneous pop frees the slot the push needs, so it is accepted when full.
    assign doPop  = pop_i & ~empty_o;
    assign doPush = push_i & (~full_o | doPop);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < els_p; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                entries_q[wrPtr_q] <= entry_i;
                wrPtr_q            <= wrPtr_q + PtrOne;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PtrOne;
            end
            if (doPush && !doPop) begin
                count_q <= count_q + CountOne;
            end else if (doPop && !doPush) begin
                count_q <= count_q - CountOne;
            end
        end
    end

endmodule

// File: rtl/bp_l15_encoder.sv
// Turns L1.5 returns into BlackParrot memory responses: pairs each return with
// the oldest tracked request, aligns load data, and hands one response at a time to BP.
module bp_l15_encoder
    import bp_l15_pkg::*;
#(
    parameter int paddr_width_p       = 40,
    parameter int mem_payload_width_p = 22,
    parameter int els_p               = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic                           req_v_i,
    input  logic                           req_store_i,
    input  logic [paddr_width_p-1:0]       req_addr_i,
    input  logic [1:0]                     req_size_i,
    input  logic [mem_payload_width_p-1:0] req_payload_i,
    output logic                           req_full_o,

    input  logic                           l15_transducer_val_i,
    input  logic [3:0]                     l15_transducer_returntype_i,
    input  logic [63:0]                    l15_transducer_data_0_i,
    input  logic [63:0]                    l15_transducer_data_1_i,
    output logic                           transducer_l15_req_ack_o,

    output logic                           resp_v_o,
    input  logic                           resp_ready_i,
    output logic                           resp_is_store_o,
    output logic [paddr_width_p-1:0]       resp_addr_o,
    output logic [1:0]                     resp_size_o,
    output logic [mem_payload_width_p-1:0] resp_payload_o,
    output logic [63:0]                    resp_data_o,

    output logic                           error_o
);

    typedef struct packed {
        logic                           store;
        logic [paddr_width_p-1:0]       addr;
        nc_size_e                       size;
        logic [mem_payload_width_p-1:0] payload;
    } entry_t;

    // Return data is big-endian within each 8-byte word; BP wants the addressed
    // bytes little-endian at bit 0, zero-extended beyond the access size.
    function automatic logic [63:0] alignLoad(input logic [3:0]  addrLow,
                                              input nc_size_e    size,
                                              input logic [63:0] data0,
                                              input logic [63:0] data1);
        logic [63:0] word;
        logic [63:0] swapped;
        logic [63:0] shifted;
        logic [63:0] mask;
        word = addrLow[3] ? data1 : data0;
        for (int i = 0; i < 8; i++) begin
            swapped[8*i +: 8] = word[8*(7-i) +: 8];
        end
        shifted = swapped >> {addrLow[2:0], 3'b000};
        case (size)
            NC_SIZE_1B: mask = 64'h0000_0000_0000_00ff;
            NC_SIZE_2B: mask = 64'h0000_0000_0000_ffff;
            NC_SIZE_4B: mask = 64'h0000_0000_ffff_ffff;
            default:    mask = 64'hffff_ffff_ffff_ffff;
        endcase
        return shifted & mask;
    endfunction

    enc_state_e                     state_q;
    logic                           respStore_q;
    logic [paddr_width_p-1:0]       respAddr_q;
    nc_size_e                       respSize_q;
    logic [mem_payload_width_p-1:0] respPayload_q;
    logic [63:0]                    respData_q;
    logic                           error_q;
    logic                           error_d;

    entry_t pushEntry;
    entry_t head;
    logic   trackerFull;
    logic   trackerEmpty;
    logic   pop;
    logic   pushDrop;
    logic   returnMatch;
    logic   returnIgnored;
    logic   badReturn;

    assign pushEntry.store   = req_store_i;
    assign pushEntry.addr    = req_addr_i;
    assign pushEntry.size    = nc_size_e'(req_size_i);
    assign pushEntry.payload = req_payload_i;

    bp_l15_req_tracker #(
        .els_p   (els_p),
        .entry_t (entry_t)
    ) tracker (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (req_v_i),
        .entry_i   (pushEntry),
        .pop_i     (pop),
        .full_o    (trackerFull),
        .empty_o   (trackerEmpty),
        .head_o    (head)
    );

    assign pop      = (state_q == SEND) & resp_ready_i;
    assign pushDrop = req_v_i & trackerFull & ~pop;

    assign returnMatch   = ~trackerEmpty &
                           (((l15_transducer_returntype_i == LOAD_RET) & ~head.store) |
                            ((l15_transducer_returntype_i == ST_ACK)   &  head.store));
    assign returnIgnored = (l15_transducer_returntype_i == INV_RET) |
                           (l15_transducer_returntype_i == INT_RET);
    assign badReturn     = (state_q == READY) & l15_transducer_val_i &
                           ~returnMatch & ~returnIgnored;

    // Every return is consumed while idle; holding ack low in SEND back-pressures L1.5.
    assign transducer_l15_req_ack_o = reset_n_i & (state_q == READY) & l15_transducer_val_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= READY;
            respStore_q   <= 1'b0;
            respAddr_q    <= '0;
            respSize_q    <= NC_SIZE_1B;
            respPayload_q <= '0;
            respData_q    <= '0;
        end else begin
            case (state_q)
                READY: begin
                    if (l15_transducer_val_i && returnMatch) begin
                        state_q       <= SEND;
                        respStore_q   <= head.store;
                        respAddr_q    <= head.addr;
                        respSize_q    <= head.size;
                        respPayload_q <= head.payload;
                        respData_q    <= head.store ? 64'd0 :
                                         alignLoad(head.addr[3:0], head.size,
                                                   l15_transducer_data_0_i,
                                                   l15_transducer_data_1_i);
                    end
                end
                SEND: begin
                    if (resp_ready_i) begin
                        state_q <= READY;
                    end
                end
                default: state_q <= READY;
            endcase
        end
    end

    always_comb begin
        error_d = error_q;
        if (pushDrop || badReturn) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign req_full_o      = trackerFull;
    assign resp_v_o        = (state_q == SEND);
    assign resp_is_store_o = respStore_q;
    assign resp_addr_o     = respAddr_q;
    assign resp_size_o     = respSize_q;
    assign resp_payload_o  = respPayload_q;
    assign resp_data_o     = respData_q;
    assign error_o         = error_q;

endmodule
